// File: rtl/io_port_ctrl.sv
// Memory-mapped I/O controller: port decode, LED/TX/RX/timer registers and read mux,
// a 4-phase req/ack transmitter with machine stall, a one-word receive buffer and a prescaled timer.
module io_port_ctrl #(
  parameter int PRESCALE    = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [4:0]  dirport,
  input  logic [15:0] outport,
  input  logic        we,
  output logic [15:0] inport,
  output logic        hold,
  input  logic [15:0] sw_in,
  output logic [15:0] led_out,
  output logic        tx_req,
  output logic [15:0] tx_data,
  input  logic        tx_ack,
  input  logic        rx_valid,
  input  logic [15:0] rx_data,
  output logic        rx_ready
);

  localparam int PS_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PS_W-1:0] PS_LAST = PS_W'(PRESCALE - 1);
  localparam logic [PS_W-1:0] PS_ONE  = PS_W'(1);

  localparam logic [4:0] ADDR_SW     = 5'h00;
  localparam logic [4:0] ADDR_STATUS = 5'h01;
  localparam logic [4:0] ADDR_RXDATA = 5'h02;
  localparam logic [4:0] ADDR_TXDATA = 5'h03;
  localparam logic [4:0] ADDR_LED    = 5'h04;
  localparam logic [4:0] ADDR_TIMER  = 5'h05;
  localparam logic [4:0] ADDR_RELOAD = 5'h06;

  typedef enum logic [1:0] {
    TX_IDLE    = 2'd0,
    TX_REQ     = 2'd1,
    TX_RELEASE = 2'd2
  } tx_state_t;

  tx_state_t                    tx_state_r;
  tx_state_t                    tx_state_nxt_s;
  logic                         tx_req_r;
  logic [15:0]                  tx_data_r;
  logic [15:0]                  led_r;
  logic                         rx_full_r;
  logic [15:0]                  rx_buf_r;
  logic                         tmr_flag_r;
  logic [15:0]                  reload_r;
  logic [15:0]                  count_r;
  logic [PS_W-1:0]              presc_r;
  logic [SYNC_STAGES-1:0][15:0] sync_r;

  logic        tx_busy_s;
  logic        tx_wr_s;
  logic        tx_accept_s;
  logic        led_wr_s;
  logic        rx_clr_s;
  logic        flag_clr_s;
  logic        reload_wr_s;
  logic        rx_xfer_s;
  logic        tmr_en_s;
  logic        tmr_tick_s;
  logic        tmr_wrap_s;
  logic [15:0] rd_data_s;

  assign tx_busy_s   = (tx_state_r != TX_IDLE);
  assign tx_wr_s     = we & (dirport == ADDR_TXDATA);
  assign tx_accept_s = tx_wr_s & ~tx_busy_s;
  assign led_wr_s    = we & (dirport == ADDR_LED);
  assign rx_clr_s    = we & (dirport == ADDR_RXDATA);
  assign flag_clr_s  = we & (dirport == ADDR_STATUS);
  assign reload_wr_s = we & (dirport == ADDR_RELOAD);

  assign rx_xfer_s  = rx_valid & ~rx_full_r;
  assign tmr_en_s   = (reload_r != 16'h0000);
  assign tmr_tick_s = tmr_en_s & (presc_r == PS_LAST);
  // A tick that finds the counter already at zero is the timer expiry.
  assign tmr_wrap_s = tmr_tick_s & (count_r == 16'h0000);

  // The machine keeps the TX write asserted until the FSM is free to take it.
  assign hold     = tx_wr_s & tx_busy_s;
  assign inport   = rd_data_s;
  assign led_out  = led_r;
  assign tx_req   = tx_req_r;
  assign tx_data  = tx_data_r;
  assign rx_ready = ~rx_full_r;

  // TX handshake next-state logic.
  always_comb begin
    tx_state_nxt_s = tx_state_r;
    case (tx_state_r)
      TX_IDLE: begin
        if (tx_accept_s) begin
          tx_state_nxt_s = TX_REQ;
        end else begin
          tx_state_nxt_s = TX_IDLE;
        end
      end
      TX_REQ: begin
        if (tx_ack) begin
          tx_state_nxt_s = TX_RELEASE;
        end else begin
          tx_state_nxt_s = TX_REQ;
        end
      end
      TX_RELEASE: begin
        if (!tx_ack) begin
          tx_state_nxt_s = TX_IDLE;
        end else begin
          tx_state_nxt_s = TX_RELEASE;
        end
      end
      default: tx_state_nxt_s = TX_IDLE;
    endcase
  end

  // TX state, registered request and latched transmit word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_state_r <= TX_IDLE;
      tx_req_r   <= 1'b0;
      tx_data_r  <= 16'h0000;
    end else begin
      tx_state_r <= tx_state_nxt_s;
      tx_req_r   <= (tx_state_nxt_s == TX_REQ);
      if (tx_accept_s) begin
        tx_data_r <= outport;
      end
    end
  end

  // LED output register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      led_r <= 16'h0000;
    end else if (led_wr_s) begin
      led_r <= outport;
    end
  end

  // Receive buffer; a transfer only happens when empty, so it overrides a same-cycle clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_full_r <= 1'b0;
      rx_buf_r  <= 16'h0000;
    end else if (rx_xfer_s) begin
      rx_full_r <= 1'b1;
      rx_buf_r  <= rx_data;
    end else if (rx_clr_s) begin
      rx_full_r <= 1'b0;
    end
  end

  // Prescaler and interval counter; a zero reload freezes both.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      reload_r <= 16'h0000;
      count_r  <= 16'h0000;
      presc_r  <= '0;
    end else if (reload_wr_s) begin
      reload_r <= outport;
      count_r  <= outport;
      presc_r  <= '0;
    end else if (tmr_en_s) begin
      if (presc_r == PS_LAST) begin
        presc_r <= '0;
        if (count_r == 16'h0000) begin
          count_r <= reload_r;
        end else begin
          count_r <= count_r - 16'd1;
        end
      end else begin
        presc_r <= presc_r + PS_ONE;
      end
    end
  end

  // Timer flag: expiry wins over a same-cycle software clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tmr_flag_r <= 1'b0;
    end else if (tmr_wrap_s) begin
      tmr_flag_r <= 1'b1;
    end else if (flag_clr_s) begin
      tmr_flag_r <= 1'b0;
    end
  end

  // Switch input synchronizer chain.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_r <= '0;
    end else begin
      sync_r[0] <= sw_in;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        sync_r[i] <= sync_r[i-1];
      end
    end
  end

  // Read-data multiplexer.
  always_comb begin
    rd_data_s = 16'h0000;
    case (dirport)
      ADDR_SW:     rd_data_s = sync_r[SYNC_STAGES-1];
      ADDR_STATUS: rd_data_s = {13'd0, tmr_flag_r, tx_busy_s, rx_full_r};
      ADDR_RXDATA: rd_data_s = rx_buf_r;
      ADDR_TXDATA: rd_data_s = tx_data_r;
      ADDR_LED:    rd_data_s = led_r;
      ADDR_TIMER:  rd_data_s = count_r;
      ADDR_RELOAD: rd_data_s = reload_r;
      default:     rd_data_s = 16'h0000;
    endcase
  end

endmodule

// File: tb/tb_io_port_ctrl.sv
// Directed self-checking bench for io_port_ctrl: register map, TX handshake with stall,
// RX buffer, prescaled timer and asynchronous reset.
module tb_io_port_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [4:0]  dirport;
  logic [15:0] outport;
  logic        we;
  logic [15:0] inport;
  logic        hold;
  logic [15:0] sw_in;
  logic [15:0] led_out;
  logic        tx_req;
  logic [15:0] tx_data;
  logic        tx_ack;
  logic        rx_valid;
  logic [15:0] rx_data;
  logic        rx_ready;

  int checks_cnt = 0;
  int fail_cnt   = 0;
  int hs_cnt     = 0;
  int stab_err   = 0;
  logic        tx_req_q  = 1'b0;
  logic [15:0] tx_hold_q = 16'h0000;

  io_port_ctrl #(.PRESCALE(16), .SYNC_STAGES(2)) dut (
    .clk(clk), .rst_n(rst_n), .dirport(dirport), .outport(outport), .we(we),
    .inport(inport), .hold(hold), .sw_in(sw_in), .led_out(led_out),
    .tx_req(tx_req), .tx_data(tx_data), .tx_ack(tx_ack),
    .rx_valid(rx_valid), .rx_data(rx_data), .rx_ready(rx_ready)
  );

  always #5 clk = ~clk;

  // Counts handshakes and flags any tx_data change while tx_req is held.
  always @(posedge clk) begin
    tx_req_q <= tx_req;
    if (tx_req && !tx_req_q) begin
      hs_cnt    <= hs_cnt + 1;
      tx_hold_q <= tx_data;
    end
    if (tx_req && tx_req_q && (tx_data != tx_hold_q)) stab_err <= stab_err + 1;
  end

  task automatic check_eq(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks_cnt++;
    if (obs !== exp) begin
      fail_cnt++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [4:0] a, input logic [15:0] d);
    dirport = a; outport = d; we = 1'b1;
    step();
    we = 1'b0;
  endtask

  task automatic rd(input string tag, input logic [4:0] a, input logic [15:0] exp);
    dirport = a;
    #1;
    check_eq(tag, inport, exp);
  endtask

  initial begin
    rst_n = 1'b0; dirport = 5'd0; outport = 16'h0000; we = 1'b0; sw_in = 16'h0000;
    tx_ack = 1'b0; rx_valid = 1'b0; rx_data = 16'h0000;
    step();
    check_eq("rst_led", led_out, 16'h0000);
    check_eq("rst_txreq", {15'd0, tx_req}, 16'h0000);
    check_eq("rst_txdata", tx_data, 16'h0000);
    check_eq("rst_rxready", {15'd0, rx_ready}, 16'h0001);
    check_eq("rst_hold", {15'd0, hold}, 16'h0000);
    rst_n = 1'b1;
    step();
    for (int a = 0; a < 7; a++) rd("rst_read", 5'(a), 16'h0000);

    // Register map
    wr(5'h04, 16'hA5A5);
    check_eq("led_out", led_out, 16'hA5A5);
    rd("rd_led", 5'h04, 16'hA5A5);
    rd("rd_1f", 5'h1F, 16'h0000);
    rd("rd_07", 5'h07, 16'h0000);
    wr(5'h05, 16'h1234);
    rd("wr_ignored_timer", 5'h05, 16'h0000);
    check_eq("led_kept", led_out, 16'hA5A5);

    // Switch synchronizer latency
    sw_in = 16'h3C5A;
    step();
    rd("sw_1cyc", 5'h00, 16'h0000);
    step();
    rd("sw_2cyc", 5'h00, 16'h3C5A);

    // Single handshake: ack after 3 cycles, release 2 later
    wr(5'h03, 16'h1234);
    check_eq("txA_req0", {15'd0, tx_req}, 16'h0001);
    check_eq("txA_data", tx_data, 16'h1234);
    rd("txA_busy", 5'h01, 16'h0002);
    for (int i = 1; i < 4; i++) begin
      step();
      check_eq("txA_req_hi", {15'd0, tx_req}, 16'h0001);
    end
    tx_ack = 1'b1;
    step();
    check_eq("txA_req_lo", {15'd0, tx_req}, 16'h0000);
    rd("txA_release", 5'h01, 16'h0002);
    step();
    rd("txA_release2", 5'h01, 16'h0002);
    tx_ack = 1'b0;
    step();
    rd("txA_idle", 5'h01, 16'h0000);

    // Blocked second write while busy
    wr(5'h03, 16'h9ABC);
    check_eq("txB_data", tx_data, 16'h9ABC);
    dirport = 5'h03; outport = 16'h5678; we = 1'b1;
    #1;
    check_eq("txB_hold0", {15'd0, hold}, 16'h0001);
    step();
    check_eq("txB_hold1", {15'd0, hold}, 16'h0001);
    step();
    check_eq("txB_hold2", {15'd0, hold}, 16'h0001);
    tx_ack = 1'b1;
    step();
    check_eq("txB_hold3", {15'd0, hold}, 16'h0001);
    check_eq("txB_req_lo", {15'd0, tx_req}, 16'h0000);
    tx_ack = 1'b0;
    step();
    check_eq("txB_hold_drop", {15'd0, hold}, 16'h0000);
    check_eq("txB_data_kept", tx_data, 16'h9ABC);
    step();
    we = 1'b0;
    check_eq("txC_req", {15'd0, tx_req}, 16'h0001);
    check_eq("txC_data", tx_data, 16'h5678);
    step();
    tx_ack = 1'b1;
    step();
    check_eq("txC_req_lo", {15'd0, tx_req}, 16'h0000);
    tx_ack = 1'b0;
    repeat (4) step();
    check_eq("tx_handshakes", 16'(hs_cnt), 16'd3);
    check_eq("tx_stable", 16'(stab_err), 16'd0);
    check_eq("txC_idle_req", {15'd0, tx_req}, 16'h0000);
    rd("rd_txdata", 5'h03, 16'h5678);

    // RX buffer
    rx_data = 16'hBEEF; rx_valid = 1'b1;
    #1;
    check_eq("rx_ready0", {15'd0, rx_ready}, 16'h0001);
    step();
    rx_valid = 1'b0;
    check_eq("rx_full", {15'd0, rx_ready}, 16'h0000);
    rd("rx_status", 5'h01, 16'h0001);
    rd("rx_data", 5'h02, 16'hBEEF);
    rx_data = 16'hDEAD; rx_valid = 1'b1;
    step();
    check_eq("rx_blocked", {15'd0, rx_ready}, 16'h0000);
    rd("rx_kept", 5'h02, 16'hBEEF);
    wr(5'h02, 16'hFFFF);
    check_eq("rx_cleared", {15'd0, rx_ready}, 16'h0001);
    step();
    rx_valid = 1'b0;
    check_eq("rx_second", {15'd0, rx_ready}, 16'h0000);
    rd("rx_data2", 5'h02, 16'hDEAD);
    wr(5'h02, 16'h0000);
    rx_data = 16'h0F0F; rx_valid = 1'b1;
    wr(5'h02, 16'h0000);
    rx_valid = 1'b0;
    check_eq("rx_xfer_wins", {15'd0, rx_ready}, 16'h0000);
    rd("rx_data3", 5'h02, 16'h0F0F);
    wr(5'h02, 16'h0000);

    // Timer: reload 3, PRESCALE 16 -> flag after 64 cycles
    wr(5'h06, 16'h0003);
    rd("tmr_count0", 5'h05, 16'h0003);
    rd("tmr_reload", 5'h06, 16'h0003);
    repeat (63) step();
    rd("tmr_pre_flag", 5'h01, 16'h0000);
    rd("tmr_count63", 5'h05, 16'h0000);
    step();
    rd("tmr_flag", 5'h01, 16'h0004);
    rd("tmr_reloaded", 5'h05, 16'h0003);
    wr(5'h01, 16'h0000);
    rd("tmr_clr", 5'h01, 16'h0000);
    repeat (62) step();
    rd("tmr_pre_flag2", 5'h01, 16'h0000);
    wr(5'h01, 16'h0000);
    rd("tmr_set_wins", 5'h01, 16'h0004);
    wr(5'h06, 16'h0000);
    wr(5'h01, 16'h0000);

    // Asynchronous reset during REQ
    wr(5'h04, 16'h00FF);
    wr(5'h03, 16'hCAFE);
    check_eq("rst_pre_req", {15'd0, tx_req}, 16'h0001);
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("arst_txreq", {15'd0, tx_req}, 16'h0000);
    check_eq("arst_led", led_out, 16'h0000);
    check_eq("arst_txdata", tx_data, 16'h0000);
    step();
    rst_n = 1'b1;
    step();
    rd("arst_status", 5'h01, 16'h0000);
    check_eq("arst_req_after", {15'd0, tx_req}, 16'h0000);

    $display("TB_RESULT checks=%0d failures=%0d", checks_cnt, fail_cnt);
    $finish;
  end

endmodule
